ex_mem_pipe: RTL
================

Name: ex_mem_pipe

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Consumes the EX result bundle: GPR write, HI/LO write, and the multi-cycle MADD/MSUB accumulator state (hilo_temp, cnt).
- During an EX stall it recirculates that accumulator state back into EX, so the second cycle of MADD/MSUB sees the first cycle's product.
- Contains the pipeline stall controller, which turns ID/EX stall requests into the 6-bit stall vector.

Parameters:
- DW, 32, data width of GPR, HI and LO.
- AW, 5, GPR address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_id  in  1  stall request from the ID stage.
- stallreq_ex  in  1  stall request from the EX stage (MADD/MSUB first cycle).
- stall  out  6  stall vector; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
- ex_wd  in  AW  EX destination register.
- ex_wreg  in  1  EX GPR write enable.
- ex_wdata  in  DW  EX GPR write data.
- ex_hi, ex_lo  in  DW each  EX HI/LO write data.
- ex_whilo  in  1  EX HI/LO write enable.
- ex_hilo_temp  in  2*DW  partial product from EX (first cycle of MADD/MSUB).
- ex_cnt  in  2  EX cycle index for the next cycle.
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo  out  as inputs  registered bundle to MEM.
- hilo_temp_fb  out  2*DW  registered partial product fed back to EX.
- cnt_fb  out  2  registered cycle index fed back to EX.

Behaviour:
- Stall vector (combinational, priority order):
  - rst → 6'b000000.
  - stallreq_ex → 6'b001111.
  - stallreq_id → 6'b000111.
  - otherwise → 6'b000000.
  - stallreq_ex wins when both requests are asserted.
- The register stage uses stall[3] (EX stalled) and stall[4] (MEM stalled), computed internally from the same logic.
- Reset: all mem_* outputs, hilo_temp_fb and cnt_fb are 0 on the cycle after rst is sampled high. Reset in the middle of a MADD/MSUB discards the partial product; cnt_fb=0.
- Case A, stall[3]=1 and stall[4]=0 (EX stalled, MEM runs):
  - Insert a bubble: mem_wd=0, mem_wreg=0, mem_wdata=0, mem_hi=0, mem_lo=0, mem_whilo=0.
  - Capture hilo_temp_fb<=ex_hilo_temp and cnt_fb<=ex_cnt.
- Case B, stall[3]=0 (EX advances):
  - Capture the full ex_* bundle into mem_*.
  - Clear hilo_temp_fb<=0 and cnt_fb<=0, so the next instruction starts at cnt 0.
- Case C, stall[3]=1 and stall[4]=1: hold every register unchanged. This is unreachable with the current controller; it is still implemented for future MEM stalls.
- Latency: one cycle from ex_* to mem_*. Feedback valid one cycle after capture.
- MADD sequence:
  - Cycle N: EX at cnt 0 asserts stallreq_ex. Case A captures cnt=01 and the product.
  - Cycle N+1: EX sees cnt_fb=01, deasserts stallreq_ex and presents the final HI/LO.
  - Case B then passes the result to MEM and clears the feedback.
- Back-to-back MADD: the second MADD sees cnt_fb=0 because of the Case B clear; no state leaks between instructions.
- cnt_fb holds whatever value EX drives; no saturation. Value 2'b11 is passed through unchanged.
- No combinational path from ex_* to mem_*. stall is combinational from the stallreq inputs only.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined:
  - Adds outputs perf_bubbles (32) and perf_ex_stalls (32).
  - perf_bubbles counts Case A cycles.
  - perf_ex_stalls counts cycles where stallreq_ex=1.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines package:
  - RstEnable, WriteEnable/WriteDisable, Stop/NoStop.
  - ZeroWord, RegBus, DoubleRegBus, RegAddrBus.
  - Stall-vector constants: STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111.
- One natural sub-module: stall_ctrl, the combinational stall vector generator. It will later be shared by the if_id, id_ex and mem_wb registers.

Test Plan:
- Reset: drive ex_wdata=32'hDEADBEEF with rst=1 for 2 cycles → all mem_*=0, hilo_temp_fb=0, cnt_fb=0, stall=0.
- Plain ADD: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h00000005, no stallreq → next cycle mem_wd=3, mem_wreg=1, mem_wdata=5, cnt_fb=0.
- MADD:
  - Cycle 1: stallreq_ex=1, ex_hilo_temp=64'h0000000200000006, ex_cnt=01 → stall=6'b001111; next cycle mem_wreg=0, mem_whilo=0, hilo_temp_fb=64'h0000000200000006, cnt_fb=01.
  - Cycle 2: stallreq_ex=0, ex_whilo=1, ex_hi=2, ex_lo=6 → mem_whilo=1, mem_hi=2, mem_lo=6, hilo_temp_fb=0, cnt_fb=0.
- Simultaneous requests: stallreq_id=1 and stallreq_ex=1 → stall=6'b001111. stallreq_id=1 alone → 6'b000111; the register still advances because stall[3]=0.
- Reset mid-MADD: assert rst the cycle after Case A (cnt_fb=01) → next cycle cnt_fb=0, hilo_temp_fb=0, mem_*=0.
- With EX_MEM_PERF_EN: 3 isolated MADDs → perf_bubbles=3, perf_ex_stalls=3. Preload the counter to 32'hFFFFFFFF, run one more bubble → wraps to 0.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared defines for the EX/MEM register stage and the pipeline stall controller.
package ex_mem_pipe_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [31:0] RegBus;
  typedef logic [63:0] DoubleRegBus;
  typedef logic [4:0]  RegAddrBus;

  // Bit order of the stall vector: 0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/ex_mem_pipe_stall_ctrl.sv
// Combinational stall vector generator; an EX request outranks an ID request.
module stall_ctrl
  import ex_mem_pipe_pkg::*;
(
  input  logic       rst,
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    if (rst == RstEnable)
      stall = STALL_NONE;
    else if (stallreq_ex == Stop)
      stall = STALL_EX;
    else if (stallreq_id == Stop)
      stall = STALL_ID;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with MADD/MSUB accumulator feedback and stall control.
// Optional cycle counters are enabled by defining EX_MEM_PERF_EN.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  output logic [5:0]      stall,
  input  logic [AW-1:0]   ex_wd,
  input  logic            ex_wreg,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW-1:0]   ex_hi,
  input  logic [DW-1:0]   ex_lo,
  input  logic            ex_whilo,
  input  logic [2*DW-1:0] ex_hilo_temp,
  input  logic [1:0]      ex_cnt,
  output logic [AW-1:0]   mem_wd,
  output logic            mem_wreg,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   mem_hi,
  output logic [DW-1:0]   mem_lo,
  output logic            mem_whilo,
  output logic [2*DW-1:0] hilo_temp_fb,
`ifdef EX_MEM_PERF_EN
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_ex_stalls,
`endif
  output logic [1:0]      cnt_fb
);

  logic ex_stalled;
  logic mem_stalled;
  logic bubble;

  stall_ctrl u_stall_ctrl (
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stall       (stall)
  );

  assign ex_stalled  = stall[3];
  assign mem_stalled = stall[4];
  assign bubble      = ex_stalled && !mem_stalled;

  // A bubble goes to MEM while EX re-executes; the partial product is kept for
  // its second cycle and cleared as soon as EX advances so nothing leaks.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      mem_wd       <= '0;
      mem_wreg     <= WriteDisable;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WriteDisable;
      hilo_temp_fb <= '0;
      cnt_fb       <= 2'b00;
    end else if (bubble) begin
      mem_wd       <= '0;
      mem_wreg     <= WriteDisable;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WriteDisable;
      hilo_temp_fb <= ex_hilo_temp;
      cnt_fb       <= ex_cnt;
    end else if (!ex_stalled) begin
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      hilo_temp_fb <= '0;
      cnt_fb       <= 2'b00;
    end
  end

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_bubbles   <= '0;
      perf_ex_stalls <= '0;
    end else begin
      if (bubble)
        perf_bubbles <= perf_bubbles + 32'd1;
      if (stallreq_ex == Stop)
        perf_ex_stalls <= perf_ex_stalls + 32'd1;
    end
  end
`endif

endmodule
